// File: rtl/bitwise_logic_pipe.sv
// Registered bitwise logic unit (AND/OR/XOR/NOR) with valid/ready flow control
// and a fold mode that reduces a multi-beat operand stream through an accumulator.
module bitwise_logic_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [1:0]       op,
  input  logic             fold,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_data,
  output logic             out_zero
);

  typedef enum logic {S_IDLE, S_FOLD} state_t;

  function automatic logic [WIDTH-1:0] f_logic(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [1:0]       sel);
    case (sel)
      2'b00:   f_logic = x & y;
      2'b01:   f_logic = x | y;
      2'b10:   f_logic = x ^ y;
      default: f_logic = ~(x | y);
    endcase
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_zero;
  logic             w_accept;
  logic             w_produce;
  logic [WIDTH-1:0] w_result;

  // in_ready covers every beat type so a stalled output also stalls a fold
  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign out_valid   = r_out_valid;
  assign output_data = r_out_data;
  assign out_zero    = r_out_zero;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_produce   = 1'b0;
    w_result    = f_logic(data1, data2, op);
    if (w_accept) begin
      if (!fold) begin
        // plain op; also aborts any fold in progress
        w_produce   = 1'b1;
        w_acc_nxt   = '0;
        w_state_nxt = S_IDLE;
      end else if (r_state == S_IDLE) begin
        if (last) begin
          w_produce = 1'b1;
        end else begin
          w_acc_nxt   = w_result;
          w_state_nxt = S_FOLD;
        end
      end else begin
        w_result = f_logic(r_acc, data1, op);
        if (last) begin
          w_produce   = 1'b1;
          w_acc_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_acc_nxt = w_result;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  // output stage: a new result may replace the one being drained in the same cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_zero  <= 1'b0;
    end else if (w_produce) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_zero  <= (w_result == '0);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed-vector bench for bitwise_logic_pipe (WIDTH=32).
module tb_bitwise_logic_pipe;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [1:0]       op;
  logic             fold;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] output_data;
  logic             out_zero;

  int n_checks = 0;
  int n_pass   = 0;

  bitwise_logic_pipe #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data1      (data1),
    .data2      (data2),
    .op         (op),
    .fold       (fold),
    .last       (last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .output_data(output_data),
    .out_zero   (out_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                      input logic f, input logic l);
    in_valid = 1'b1;
    data1    = a;
    data2    = b;
    op       = o;
    fold     = f;
    last     = l;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    fold     = 1'b0;
    last     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; data1 = '0; data2 = '0; op = 2'b00;
    fold = 1'b0; last = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  output_data, 32'h0);
    chk("rst_zero",  {31'd0, out_zero}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;

    // single OR
    beat(32'hF0F0_0000, 32'h0000_0F0F, 2'b01, 1'b0, 1'b0);
    tick();
    chk("or_valid", {31'd0, out_valid}, 32'd1);
    chk("or_data",  output_data, 32'hF0F0_0F0F);
    chk("or_zero",  {31'd0, out_zero}, 32'd0);
    idle(); tick();
    chk("or_drain", {31'd0, out_valid}, 32'd0);

    // ops sweep back-to-back, one result per cycle
    beat(32'hFFFF_0000, 32'hFF00_FF00, 2'b00, 1'b0, 1'b0); tick();
    chk("and_data", output_data, 32'hFF00_0000);
    beat(32'hFFFF_0000, 32'hFF00_FF00, 2'b10, 1'b0, 1'b0); tick();
    chk("xor_valid", {31'd0, out_valid}, 32'd1);
    chk("xor_data", output_data, 32'h00FF_FF00);
    beat(32'hFFFF_0000, 32'hFF00_FF00, 2'b11, 1'b0, 1'b0); tick();
    chk("nor_data", output_data, 32'h0000_00FF);
    chk("nor_zero", {31'd0, out_zero}, 32'd0);
    idle(); tick();
    chk("sweep_drain", {31'd0, out_valid}, 32'd0);

    // 3-beat OR fold
    beat(32'h1, 32'h2, 2'b01, 1'b1, 1'b0); tick();
    chk("fold1_novalid", {31'd0, out_valid}, 32'd0);
    beat(32'h4, 32'h0, 2'b01, 1'b1, 1'b0); tick();
    chk("fold2_novalid", {31'd0, out_valid}, 32'd0);
    beat(32'h8, 32'h0, 2'b01, 1'b1, 1'b1); tick();
    chk("fold_valid", {31'd0, out_valid}, 32'd1);
    chk("fold_data",  output_data, 32'h0000_000F);
    idle(); tick();
    chk("fold_drain", {31'd0, out_valid}, 32'd0);

    // backpressure
    out_ready = 1'b0;
    beat(32'hA5A5_A5A5, 32'hFFFF_0000, 2'b00, 1'b0, 1'b0); tick();
    chk("bp_data", output_data, 32'hA5A5_0000);
    chk("bp_ready", {31'd0, in_ready}, 32'd0);
    beat(32'h1, 32'h2, 2'b01, 1'b0, 1'b0); tick();
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_hold_data", output_data, 32'hA5A5_0000);
    tick();
    chk("bp_hold_data2", output_data, 32'hA5A5_0000);
    out_ready = 1'b1; #1;
    chk("bp_ready_up", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_next_data", output_data, 32'h0000_0003);
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
    idle(); tick();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    // abort a fold with a plain op
    beat(32'hFFFF_FFFF, 32'h0000_FFFF, 2'b00, 1'b1, 1'b0); tick();
    chk("abort_novalid", {31'd0, out_valid}, 32'd0);
    beat(32'h5, 32'h3, 2'b10, 1'b0, 1'b0); tick();
    chk("abort_data", output_data, 32'h0000_0006);
    // one-beat fold must use fresh operands (IDLE), giving 1|2
    beat(32'h1, 32'h2, 2'b01, 1'b1, 1'b1); tick();
    chk("post_abort_1beat", output_data, 32'h0000_0003);
    beat(32'h10, 32'h20, 2'b01, 1'b1, 1'b0); tick();
    chk("fresh_fold_novalid", {31'd0, out_valid}, 32'd0);
    beat(32'h1, 32'h0, 2'b10, 1'b1, 1'b1); tick();
    chk("fresh_fold_data", output_data, 32'h0000_0031);
    idle(); tick();

    // reset with a held result
    out_ready = 1'b0;
    beat(32'h12, 32'h30, 2'b01, 1'b0, 1'b0); tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    idle(); reset = 1'b1; tick();
    chk("rst2_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_data",  output_data, 32'h0);
    chk("rst2_zero",  {31'd0, out_zero}, 32'd0);
    reset = 1'b0; out_ready = 1'b1;

    // reset mid-fold discards acc/state
    beat(32'hF0, 32'h0F, 2'b10, 1'b1, 1'b0); tick();
    idle(); reset = 1'b1; tick();
    reset = 1'b0;
    beat(32'h1, 32'h2, 2'b01, 1'b1, 1'b1); tick();
    chk("rst_fold_1beat", output_data, 32'h0000_0003);
    chk("rst_fold_valid", {31'd0, out_valid}, 32'd1);
    beat(32'h0, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b0); tick();
    chk("zero_data", output_data, 32'h0);
    chk("zero_flag", {31'd0, out_zero}, 32'd1);
    idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
